tipi_rpi_link: RTL

Raspberry Pi-side serial link for the TIPI board. It is the other end of the 0x5fff/0x5ffd latches and the 0x5ffb/0x5ff9 read paths. The Pi bit-bangs GPIO lines to:
- shift out the TI-written data/control bytes (TD/TC);
- shift in the Pi-to-TI data/control bytes (RD/RC), which drive the TI read transceivers.

All Pi lines are asynchronous to `clk` and are synchronized inside the block.

---
 rtl/tipi_pkg.sv | 24 ++
 rtl/tipi_sync.sv | 52 +++++
 rtl/tipi_rpi_link.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/tipi_pkg.sv
// Shared types and constants for the TIPI Raspberry Pi serial link.
package tipi_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Register select as driven on r_cd
  localparam logic SEL_DATA = 1'b0;
  localparam logic SEL_CTRL = 1'b1;

  // Transfer direction as driven on r_rt
  localparam logic DIR_WRITE = 1'b0;
  localparam logic DIR_READ  = 1'b1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } link_state_e;

  // 4-bit increment that sticks at 15 so runaway clocking cannot wrap to a valid count
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/tipi_sync.sv
// Single-bit synchronizer for an asynchronous Pi GPIO line, with an optional
// rising-edge pulse taken from the synchronized output.
module tipi_sync #(
  parameter int STAGES  = 2,
  parameter bit EDGE_EN = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out,
  output logic rise
);

  logic [STAGES-1:0] stage_q;
  logic [STAGES-1:0] stage_d;

  // Shift the raw pin into the synchronizer chain
  always_comb begin
    stage_d = {stage_q[STAGES-2:0], async_in};
  end

  // Synchronizer flops, cleared by reset
  always_ff @(posedge clk) begin
    if (!rst_n) stage_q <= '0;
    else        stage_q <= stage_d;
  end

  assign sync_out = stage_q[STAGES-1];

  generate
    if (EDGE_EN) begin : g_edge
      logic prev_q;
      logic prev_d;

      // Remember last synchronized level for edge detection
      always_comb begin
        prev_d = stage_q[STAGES-1];
      end

      // Previous-level flop
      always_ff @(posedge clk) begin
        if (!rst_n) prev_q <= 1'b0;
        else        prev_q <= prev_d;
      end

      assign rise = stage_q[STAGES-1] & ~prev_q;
    end else begin : g_no_edge
      assign rise = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/tipi_rpi_link.sv
// Pi-side serial link of the TIPI board: the Pi bit-bangs TD/TC out of the
// FPGA and RD/RC into it through a single shift register.
module tipi_rpi_link
  import tipi_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] td_in,
  input  logic [WIDTH-1:0] tc_in,
  input  logic             r_clk,
  input  logic             r_le,
  input  logic             r_rt,
  input  logic             r_cd,
  input  logic             r_dout,
  output logic             r_din,
  output logic [WIDTH-1:0] rd_q,
  output logic [WIDTH-1:0] rc_q,
  output logic             rd_stb,
  output logic             rc_stb,
  output logic             frame_err,
  output logic             busy
);

  // Bit count that makes a write frame acceptable
  localparam logic [3:0] FULL_CNT = 4'(WIDTH);

  // Pin order: 0 r_clk, 1 r_le, 2 r_rt, 3 r_cd, 4 r_dout
  logic [4:0] pin_async;
  logic [4:0] pin_sync;
  logic [1:0] edge_rise;          // rises of r_clk (0) and r_le (1)
  logic [2:0] level_rise_unused;  // level-only lines carry no edge

  assign pin_async = {r_dout, r_cd, r_rt, r_le, r_clk};

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_sync
      if (gi < 2) begin : g_edge_pin
        tipi_sync #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b1)) u_sync (
          .clk      (clk),
          .rst_n    (rst_n),
          .async_in (pin_async[gi]),
          .sync_out (pin_sync[gi]),
          .rise     (edge_rise[gi])
        );
      end else begin : g_level_pin
        tipi_sync #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_sync (
          .clk      (clk),
          .rst_n    (rst_n),
          .async_in (pin_async[gi]),
          .sync_out (pin_sync[gi]),
          .rise     (level_rise_unused[gi-2])
        );
      end
    end
  endgenerate

  logic clk_rise, le_rise, rt_s, cd_s, dout_s;
  assign clk_rise = edge_rise[0];
  assign le_rise  = edge_rise[1];
  assign rt_s     = pin_sync[2];
  assign cd_s     = pin_sync[3];
  assign dout_s   = pin_sync[4];

  link_state_e      state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             r_din_q, r_din_d;
  logic [WIDTH-1:0] rd_d, rc_d;
  logic             rd_stb_d, rc_stb_d, frame_err_d;

  // Next-state: latch edge has priority over shift edge in the same cycle
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    rd_d        = rd_q;
    rc_d        = rc_q;
    rd_stb_d    = 1'b0;
    rc_stb_d    = 1'b0;
    frame_err_d = 1'b0;
    r_din_d     = sr_q[WIDTH-1];

    if (le_rise) begin
      cnt_d = 4'd0;
      if (rt_s == DIR_READ) begin
        // Snapshot the TI-written byte; later input changes are ignored
        sr_d    = (cd_s == SEL_CTRL) ? tc_in : td_in;
        state_d = SHIFT;
      end else begin
        state_d = IDLE;
        if (cnt_q == FULL_CNT) begin
          if (cd_s == SEL_CTRL) begin
            rc_d     = sr_q;
            rc_stb_d = 1'b1;
          end else begin
            rd_d     = sr_q;
            rd_stb_d = 1'b1;
          end
        end else begin
          frame_err_d = 1'b1;
        end
      end
    end else if (clk_rise) begin
      // Reads shift zeros in so r_dout noise cannot leak into sr
      sr_d    = {sr_q[WIDTH-2:0], (rt_s == DIR_READ) ? 1'b0 : dout_s};
      cnt_d   = sat_inc4(cnt_q);
      state_d = SHIFT;
    end
  end

  // State, shift register and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      cnt_q     <= 4'd0;
      r_din_q   <= 1'b0;
      rd_q      <= '0;
      rc_q      <= '0;
      rd_stb    <= 1'b0;
      rc_stb    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      r_din_q   <= r_din_d;
      rd_q      <= rd_d;
      rc_q      <= rc_d;
      rd_stb    <= rd_stb_d;
      rc_stb    <= rc_stb_d;
      frame_err <= frame_err_d;
    end
  end

  assign r_din = r_din_q;
  assign busy  = (state_q == SHIFT);

endmodule
